// File: rtl/fmes_bcd_conv_pkg.sv
// Shared constants and state encoding for the frequency-meter BCD conversion path.
// The meter and display blocks reuse these same definitions.
package fmes_bcd_conv_pkg;

  localparam int FMES_NBIT = 16;
  localparam int FMES_NDIG = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fmes_bcd_conv_adj.sv
// Single BCD digit correction used before each double-dabble shift.
// Applies +3 to a digit of 5 or more, so that the next left shift carries correctly.
module bcd_dig_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  assign dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;

endmodule

// File: rtl/fmes_bcd_conv.sv
// Captures the frequency word on the divider strobe and converts it to packed BCD.
// Uses a serial shift-and-add-3 with a leading-zero blank mask and a one-cycle done strobe.
module fmes_bcd_conv
  import fmes_bcd_conv_pkg::*;
#(
  parameter int N_BIT = FMES_NBIT,
  parameter int N_DIG = FMES_NDIG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               st,
  input  logic [N_BIT-1:0]   F,
  output logic [4*N_DIG-1:0] BCD,
  output logic [N_DIG-1:0]   BL,
  output logic               busy,
  output logic               ok_BCD
);

  localparam int CNT_W = $clog2(N_BIT + 1);
  localparam logic [N_DIG-1:0]  BL_RST   = {{(N_DIG-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_BIT);

  state_t             state_q, state_d;
  logic [N_BIT-1:0]   bin_q, bin_d;
  logic [4*N_DIG-1:0] acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4*N_DIG-1:0] bcd_q, bcd_d;
  logic [N_DIG-1:0]   bl_q, bl_d;
  logic               ok_q, ok_d;

  // A digit is blanked while it and every digit above it are zero; units never blank.
  function automatic logic [N_DIG-1:0] blank_mask(input logic [4*N_DIG-1:0] v);
    logic zero_above;
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      zero_above    = zero_above & (v[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_above;
    end
  endfunction

  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_dig_adj u_adj (
      .dig_i (acc_q[4*g +: 4]),
      .dig_o (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bl_d    = bl_q;
    ok_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st) begin
          bin_d   = F;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The cycle after the last shift only hands over to DONE, giving the fixed latency.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          {acc_d, bin_d} = {acc_adj, bin_q} << 1;
          cnt_d          = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        bcd_d   = acc_q;
        bl_d    = blank_mask(acc_q);
        ok_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bl_q    <= BL_RST;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bl_q    <= bl_d;
      ok_q    <= ok_d;
    end
  end

  assign BCD    = bcd_q;
  assign BL     = bl_q;
  assign busy   = (state_q != S_IDLE);
  assign ok_BCD = ok_q;

endmodule

// File: tb/tb_fmes_bcd_conv.sv
// Bench for fmes_bcd_conv: a cycle-level reference model checked every clock,
// plus directed vectors with hand-computed literal results.
module tb_fmes_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st = 1'b0;
  logic [15:0] F = '0;
  logic [19:0] BCD;
  logic [4:0]  BL;
  logic        busy;
  logic        ok_BCD;

  int checks = 0;
  int errors = 0;

  fmes_bcd_conv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .st     (st),
    .F      (F),
    .BCD    (BCD),
    .BL     (BL),
    .busy   (busy),
    .ok_BCD (ok_BCD)
  );

  always #10 clk = ~clk;

  // Reference model: decimal digits by division, blanking by magnitude, 18-cycle latency.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] to_bl(input int unsigned v);
    logic [4:0] m;
    int unsigned p;
    m = '0;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_busy = 0;
  int          m_due = 0;
  int unsigned m_val = 0;
  logic [19:0] m_bcd = '0;
  logic [4:0]  m_bl = 5'b11110;
  bit          m_ok = 0;

  always @(posedge clk) begin
    cyc++;
    m_ok = 0;
    if (!rst_n) begin
      m_busy = 0;
      m_bcd  = '0;
      m_bl   = 5'b11110;
      chk_en = 1;
    end else if (m_busy) begin
      if (cyc == m_due) begin
        m_bcd  = to_bcd(m_val);
        m_bl   = to_bl(m_val);
        m_ok   = 1;
        m_busy = 0;
      end
    end else if (st) begin
      m_busy = 1;
      m_val  = F;
      m_due  = cyc + 18;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   32'(busy),   32'(m_busy));
      check("ok_BCD", 32'(ok_BCD), 32'(m_ok));
      check("BCD",    32'(BCD),    32'(m_bcd));
      check("BL",     32'(BL),     32'(m_bl));
    end
  end

  // Pulse st for one clock; returns the edge count at which it was sampled.
  task automatic start(input logic [15:0] f, output int acc);
    @(posedge clk); #1;
    st = 1'b1;
    F  = f;
    @(posedge clk); #1;
    acc = cyc;
    st = 1'b0;
  endtask

  task automatic wait_ok(input int acc, input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ok_BCD) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: ok_BCD not seen within 40 cycles", nm);
    end else begin
      check({nm, "_latency"}, 32'(cyc - acc), 32'd18);
    end
  endtask

  task automatic conv(input logic [15:0] f, input logic [19:0] eb, input logic [4:0] el,
                      input string nm);
    int acc;
    start(f, acc);
    wait_ok(acc, nm);
    check({nm, "_bcd"}, 32'(BCD), 32'(eb));
    check({nm, "_bl"},  32'(BL),  32'(el));
  endtask

  initial begin
    int acc;
    int nok;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_bcd",  32'(BCD),    32'h0);
    check("rst_bl",   32'(BL),     32'b11110);
    check("rst_busy", 32'(busy),   32'h0);
    check("rst_ok",   32'(ok_BCD), 32'h0);

    conv(16'd3438, 20'h03438, 5'b10000, "t1");
    conv(16'd0,    20'h00000, 5'b11110, "t2_zero");
    conv(16'hFFFF, 20'h65535, 5'b00000, "t2_max");

    // st during busy must be ignored
    start(16'd9, acc);
    repeat (4) begin @(posedge clk); #1; end
    st = 1'b1;
    F  = 16'd1234;
    @(posedge clk); #1;
    st = 1'b0;
    wait_ok(acc, "t3");
    check("t3_bcd", 32'(BCD), 32'h00009);
    check("t3_bl",  32'(BL),  32'b11110);
    nok = 0;
    repeat (25) begin @(negedge clk); if (ok_BCD) nok++; end
    check("t3_no_second", 32'(nok), 32'd0);

    // reset mid-conversion aborts without publishing partial data
    start(16'd50000, acc);
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_bcd",  32'(BCD),  32'h0);
    nok = 0;
    repeat (25) begin @(negedge clk); if (ok_BCD) nok++; end
    check("t4_no_ok", 32'(nok), 32'd0);
    conv(16'd100, 20'h00100, 5'b11000, "t4_fresh");

    // back-to-back: new st on the ok_BCD cycle
    start(16'd1111, acc);
    wait_ok(acc, "t5a");
    check("t5a_bcd", 32'(BCD), 32'h01111);
    st = 1'b1;
    F  = 16'd2222;
    @(posedge clk); #1;
    acc = cyc;
    st = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_hold", 32'(BCD), 32'h01111);
    wait_ok(acc, "t5b");
    check("t5b_bcd", 32'(BCD), 32'h02222);
    check("t5b_bl",  32'(BL),  32'b10000);

    for (int n = 0; n < 1000; n++) begin
      start(16'($urandom), acc);
      wait_ok(acc, "t6");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
